// File: rtl/count_seq_checker_pkg.sv
// Shared types and default parameters for the counter sequence checker.
package count_seq_checker_pkg;

   localparam int DEF_WIDTH      = 4;
   localparam int DEF_LOCK_COUNT = 4;
   localparam int DEF_LOSS_COUNT = 3;
   localparam int DEF_CNT_W      = 8;

   typedef enum logic [1:0] {
      ACQ    = 2'd0,
      SYNC   = 2'd1,
      LOCKED = 2'd2
   } state_t;

endpackage

// File: rtl/count_seq_checker_if.sv
// Sample/control inputs and status outputs of the counter sequence checker.
interface count_seq_checker_if
   import count_seq_checker_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) ();

   logic [WIDTH-1:0] din;
   logic             en;
   logic             clear;
   logic             locked;
   logic             err_pulse;
   logic [CNT_W-1:0] err_count;
   logic [CNT_W-1:0] wrap_count;

   modport master (
      output din, en, clear,
      input  locked, err_pulse, err_count, wrap_count
   );

   modport slave (
      input  din, en, clear,
      output locked, err_pulse, err_count, wrap_count
   );

endinterface

// File: rtl/count_seq_checker_sync2.sv
// Two-flop synchronizer for the pin counter value; each bit is captured independently.
module count_seq_checker_sync2 #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_reg;
   logic [WIDTH-1:0] sync_reg;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               meta_reg[gi] <= 1'b0;
               sync_reg[gi] <= 1'b0;
            end else begin
               meta_reg[gi] <= d[gi];
               sync_reg[gi] <= meta_reg[gi];
            end
         end
      end
   endgenerate

   assign q = sync_reg;

endmodule

// File: rtl/count_seq_checker.sv
// Checks that each enabled synchronized sample is the previous one plus one,
// tracking lock, counting sequence errors and wraps while locked.
module count_seq_checker
   import count_seq_checker_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int LOCK_COUNT = DEF_LOCK_COUNT,
   parameter int LOSS_COUNT = DEF_LOSS_COUNT,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic          clk,
   input  logic          rst,
   count_seq_checker_if.slave bus
);

   localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
   localparam int MISS_W = $clog2(LOSS_COUNT + 1);

   logic [WIDTH-1:0]  s;
   state_t            state_reg, state_next;
   logic [WIDTH-1:0]  prev_reg, prev_next;
   logic [RUN_W-1:0]  run_reg, run_next, run_inc;
   logic [MISS_W-1:0] miss_reg, miss_next, miss_inc;
   logic [CNT_W-1:0]  err_count_reg, err_count_next;
   logic [CNT_W-1:0]  wrap_count_reg, wrap_count_next;
   logic              err_pulse_reg, err_pulse_next;
   logic              err_inc, wrap_inc;
   logic              good;

   count_seq_checker_sync2 #(.WIDTH(WIDTH)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (bus.din),
      .q   (s)
   );

   // Comparison is at WIDTH bits so 2^WIDTH-1 -> 0 counts as a good step.
   assign good     = (s == prev_reg + WIDTH'(1));
   assign run_inc  = run_reg + RUN_W'(1);
   assign miss_inc = miss_reg + MISS_W'(1);

   always_comb begin
      state_next     = state_reg;
      prev_next      = prev_reg;
      run_next       = run_reg;
      miss_next      = miss_reg;
      err_pulse_next = 1'b0;
      err_inc        = 1'b0;
      wrap_inc       = 1'b0;
      if (bus.en) begin
         prev_next = s;
         unique case (state_reg)
            ACQ: begin
               state_next = SYNC;
               run_next   = '0;
            end
            SYNC: begin
               if (good) begin
                  if (run_inc == RUN_W'(LOCK_COUNT)) begin
                     state_next = LOCKED;
                     run_next   = '0;
                     miss_next  = '0;
                  end else begin
                     run_next = run_inc;
                  end
               end else begin
                  run_next = '0;
               end
            end
            LOCKED: begin
               if (good) begin
                  miss_next = '0;
                  wrap_inc  = (s == '0);
               end else begin
                  err_pulse_next = 1'b1;
                  err_inc        = 1'b1;
                  if (miss_inc == MISS_W'(LOSS_COUNT)) begin
                     state_next = SYNC;
                     run_next   = '0;
                     miss_next  = '0;
                  end else begin
                     miss_next = miss_inc;
                  end
               end
            end
            default: state_next = ACQ;
         endcase
      end
   end

   // clear has priority over a same-cycle count event.
   always_comb begin
      err_count_next  = err_count_reg;
      wrap_count_next = wrap_count_reg;
      if (bus.clear) begin
         err_count_next  = '0;
         wrap_count_next = '0;
      end else begin
         if (err_inc && (err_count_reg != '1))
            err_count_next = err_count_reg + CNT_W'(1);
         if (wrap_inc)
            wrap_count_next = wrap_count_reg + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= ACQ;
         prev_reg       <= '0;
         run_reg        <= '0;
         miss_reg       <= '0;
         err_count_reg  <= '0;
         wrap_count_reg <= '0;
         err_pulse_reg  <= 1'b0;
      end else begin
         state_reg      <= state_next;
         prev_reg       <= prev_next;
         run_reg        <= run_next;
         miss_reg       <= miss_next;
         err_count_reg  <= err_count_next;
         wrap_count_reg <= wrap_count_next;
         err_pulse_reg  <= err_pulse_next;
      end
   end

   assign bus.locked     = (state_reg == LOCKED);
   assign bus.err_pulse  = err_pulse_reg;
   assign bus.err_count  = err_count_reg;
   assign bus.wrap_count = wrap_count_reg;

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed bench for count_seq_checker: lock, wrap, glitch, loss/relock, gating, clear, saturation, reset.
module tb_count_seq_checker;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   int   cnt;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   count_seq_checker_if #(.WIDTH(4), .CNT_W(8)) bus ();
   count_seq_checker_if #(.WIDTH(4), .CNT_W(2)) bus2 ();

   count_seq_checker #(.WIDTH(4), .LOCK_COUNT(4), .LOSS_COUNT(3), .CNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Wide loss window so five consecutive bad steps stay inside LOCKED.
   count_seq_checker #(.WIDTH(4), .LOCK_COUNT(4), .LOSS_COUNT(8), .CNT_W(2)) dut_sat (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   task automatic step(input logic [3:0] v, input logic e, input logic c);
      bus.din   = v;
      bus.en    = e;
      bus.clear = c;
      @(posedge clk);
      #1;
      $display("step t=%0t din=%h en=%b clr=%b locked=%b pulse=%b err=%0d wrap=%0d",
               $time, v, e, c, bus.locked, bus.err_pulse, bus.err_count, bus.wrap_count);
   endtask

   task automatic step2(input logic [3:0] v);
      bus2.din   = v;
      bus2.en    = 1'b1;
      bus2.clear = 1'b0;
      @(posedge clk);
      #1;
      $display("sat  t=%0t din=%h locked=%b pulse=%b err=%0d",
               $time, v, bus2.locked, bus2.err_pulse, bus2.err_count);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.din = 4'd0;  bus.en = 1'b0;  bus.clear = 1'b0;
      bus2.din = 4'd0; bus2.en = 1'b0; bus2.clear = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus.locked !== 1'b0) begin failures++; $display("FAIL reset_locked: got %b expected 0", bus.locked); end
      checks++; if (bus.err_pulse !== 1'b0) begin failures++; $display("FAIL reset_pulse: got %b expected 0", bus.err_pulse); end
      checks++; if (bus.err_count !== 8'd0) begin failures++; $display("FAIL reset_err: got %0d expected 0", bus.err_count); end
      checks++; if (bus.wrap_count !== 8'd0) begin failures++; $display("FAIL reset_wrap: got %0d expected 0", bus.wrap_count); end
      checks++; if (bus2.locked !== 1'b0) begin failures++; $display("FAIL reset_sat_locked: got %b expected 0", bus2.locked); end
   endtask

   // Expects rst already released with din=0; the first enabled edge is seen in ACQ.
   task automatic test_clean_lock();
      for (int j = 0; j < 9; j++) begin
         step(4'(j), 1'b1, 1'b0);
         checks++; if (bus.err_pulse !== 1'b0) begin failures++; $display("FAIL lock_pulse step%0d: got %b expected 0", j, bus.err_pulse); end
         if (j == 5) begin
            checks++; if (bus.locked !== 1'b0) begin failures++; $display("FAIL lock_early: got %b expected 0", bus.locked); end
         end
         if (j == 6) begin
            checks++; if (bus.locked !== 1'b1) begin failures++; $display("FAIL lock_rise: got %b expected 1", bus.locked); end
         end
      end
      checks++; if (bus.err_count !== 8'd0) begin failures++; $display("FAIL lock_err: got %0d expected 0", bus.err_count); end
      cnt = 9;
   endtask

   task automatic test_wrap();
      for (int j = 0; j < 48; j++) begin
         step(4'(cnt), 1'b1, 1'b0);
         cnt++;
      end
      checks++; if (bus.wrap_count !== 8'd3) begin failures++; $display("FAIL wrap_count: got %0d expected 3", bus.wrap_count); end
      checks++; if (bus.err_count !== 8'd0) begin failures++; $display("FAIL wrap_err: got %0d expected 0", bus.err_count); end
      checks++; if (bus.locked !== 1'b1) begin failures++; $display("FAIL wrap_locked: got %b expected 1", bus.locked); end
   endtask

   task automatic test_glitch();
      while ((cnt % 16) != 5) begin
         step(4'(cnt), 1'b1, 1'b0);
         cnt++;
      end
      step(4'd9, 1'b1, 1'b0);
      step(4'd6, 1'b1, 1'b0);
      step(4'd7, 1'b1, 1'b0);
      checks++; if (bus.err_pulse !== 1'b1) begin failures++; $display("FAIL glitch_pulse1: got %b expected 1", bus.err_pulse); end
      checks++; if (bus.err_count !== 8'd1) begin failures++; $display("FAIL glitch_err1: got %0d expected 1", bus.err_count); end
      step(4'd8, 1'b1, 1'b0);
      checks++; if (bus.err_pulse !== 1'b1) begin failures++; $display("FAIL glitch_pulse2: got %b expected 1", bus.err_pulse); end
      checks++; if (bus.err_count !== 8'd2) begin failures++; $display("FAIL glitch_err2: got %0d expected 2", bus.err_count); end
      checks++; if (bus.locked !== 1'b1) begin failures++; $display("FAIL glitch_locked: got %b expected 1", bus.locked); end
      step(4'd9, 1'b1, 1'b0);
      checks++; if (bus.err_pulse !== 1'b0) begin failures++; $display("FAIL glitch_recover: got %b expected 0", bus.err_pulse); end
      checks++; if (bus.err_count !== 8'd2) begin failures++; $display("FAIL glitch_err_hold: got %0d expected 2", bus.err_count); end
      cnt = 10;
   endtask

   task automatic test_loss_relock();
      step(4'(cnt), 1'b1, 1'b1);
      cnt++;
      checks++; if (bus.err_count !== 8'd0) begin failures++; $display("FAIL clear_err: got %0d expected 0", bus.err_count); end
      checks++; if (bus.wrap_count !== 8'd0) begin failures++; $display("FAIL clear_wrap: got %0d expected 0", bus.wrap_count); end
      for (int i = 0; i < 5; i++) begin
         step(4'd7, 1'b1, 1'b0);
         if (i == 3) begin
            checks++; if (bus.locked !== 1'b1) begin failures++; $display("FAIL loss_early: got %b expected 1", bus.locked); end
            checks++; if (bus.err_count !== 8'd2) begin failures++; $display("FAIL loss_err2: got %0d expected 2", bus.err_count); end
         end
      end
      checks++; if (bus.locked !== 1'b0) begin failures++; $display("FAIL loss_fall: got %b expected 0", bus.locked); end
      checks++; if (bus.err_pulse !== 1'b1) begin failures++; $display("FAIL loss_pulse: got %b expected 1", bus.err_pulse); end
      checks++; if (bus.err_count !== 8'd3) begin failures++; $display("FAIL loss_err3: got %0d expected 3", bus.err_count); end
      for (int v = 8; v <= 13; v++) begin
         step(4'(v), 1'b1, 1'b0);
         if (v == 8) begin
            checks++; if (bus.err_pulse !== 1'b0) begin failures++; $display("FAIL sync_no_pulse: got %b expected 0", bus.err_pulse); end
            checks++; if (bus.err_count !== 8'd3) begin failures++; $display("FAIL sync_no_count: got %0d expected 3", bus.err_count); end
         end
         if (v == 12) begin
            checks++; if (bus.locked !== 1'b0) begin failures++; $display("FAIL relock_early: got %b expected 0", bus.locked); end
         end
      end
      checks++; if (bus.locked !== 1'b1) begin failures++; $display("FAIL relock_rise: got %b expected 1", bus.locked); end
      cnt = 14;
   endtask

   task automatic test_en_clear();
      logic [3:0] junk [4];
      junk[0] = 4'd3; junk[1] = 4'd12; junk[2] = 4'd0; junk[3] = 4'd9;
      for (int i = 0; i < 6; i++) begin
         step((i < 4) ? junk[i] : 4'(cnt - 6 + i), 1'b0, 1'b0);
         checks++; if (bus.err_pulse !== 1'b0) begin failures++; $display("FAIL gate_pulse%0d: got %b expected 0", i, bus.err_pulse); end
         checks++; if (bus.err_count !== 8'd3) begin failures++; $display("FAIL gate_err%0d: got %0d expected 3", i, bus.err_count); end
         checks++; if (bus.wrap_count !== 8'd0) begin failures++; $display("FAIL gate_wrap%0d: got %0d expected 0", i, bus.wrap_count); end
      end
      step(4'd14, 1'b1, 1'b0);
      step(4'd15, 1'b1, 1'b0);
      checks++; if (bus.err_pulse !== 1'b0) begin failures++; $display("FAIL gate_resume: got %b expected 0", bus.err_pulse); end
      checks++; if (bus.locked !== 1'b1) begin failures++; $display("FAIL gate_locked: got %b expected 1", bus.locked); end
      step(4'd8, 1'b1, 1'b0);
      step(4'd1, 1'b1, 1'b0);
      step(4'd2, 1'b1, 1'b1);
      checks++; if (bus.err_count !== 8'd0) begin failures++; $display("FAIL clr_bad_err: got %0d expected 0", bus.err_count); end
      checks++; if (bus.err_pulse !== 1'b1) begin failures++; $display("FAIL clr_bad_pulse: got %b expected 1", bus.err_pulse); end
      step(4'd3, 1'b1, 1'b0);
      checks++; if (bus.err_count !== 8'd1) begin failures++; $display("FAIL post_clr_err: got %0d expected 1", bus.err_count); end
      step(4'd4, 1'b1, 1'b0);
      checks++; if (bus.err_pulse !== 1'b0) begin failures++; $display("FAIL post_clr_good: got %b expected 0", bus.err_pulse); end
      checks++; if (bus.locked !== 1'b1) begin failures++; $display("FAIL post_clr_locked: got %b expected 1", bus.locked); end
   endtask

   task automatic test_saturation();
      bus.en = 1'b0;
      for (int j = 0; j < 15; j++) begin
         step2((j < 8) ? 4'(j + 1) : 4'd2);
         if (j == 4) begin
            checks++; if (bus2.locked !== 1'b0) begin failures++; $display("FAIL sat_lock_early: got %b expected 0", bus2.locked); end
         end
         if (j == 5) begin
            checks++; if (bus2.locked !== 1'b1) begin failures++; $display("FAIL sat_lock: got %b expected 1", bus2.locked); end
         end
         if (j == 12) begin
            checks++; if (bus2.err_count !== 2'd3) begin failures++; $display("FAIL sat_err3: got %0d expected 3", bus2.err_count); end
         end
      end
      checks++; if (bus2.err_count !== 2'd3) begin failures++; $display("FAIL sat_hold: got %0d expected 3", bus2.err_count); end
      checks++; if (bus2.err_pulse !== 1'b1) begin failures++; $display("FAIL sat_pulse: got %b expected 1", bus2.err_pulse); end
      checks++; if (bus2.locked !== 1'b1) begin failures++; $display("FAIL sat_locked: got %b expected 1", bus2.locked); end
   endtask

   task automatic test_reset_mid();
      #2;
      rst = 1'b1;
      #1;
      checks++; if (bus.err_count !== 8'd0) begin failures++; $display("FAIL mid_rst_err: got %0d expected 0", bus.err_count); end
      checks++; if (bus.locked !== 1'b0) begin failures++; $display("FAIL mid_rst_locked: got %b expected 0", bus.locked); end
      checks++; if (bus.wrap_count !== 8'd0) begin failures++; $display("FAIL mid_rst_wrap: got %0d expected 0", bus.wrap_count); end
      checks++; if (bus2.err_count !== 2'd0) begin failures++; $display("FAIL mid_rst_sat_err: got %0d expected 0", bus2.err_count); end
      checks++; if (bus2.err_pulse !== 1'b0) begin failures++; $display("FAIL mid_rst_sat_pulse: got %b expected 0", bus2.err_pulse); end
      checks++; if (bus2.locked !== 1'b0) begin failures++; $display("FAIL mid_rst_sat_locked: got %b expected 0", bus2.locked); end
      bus.din = 4'd0;  bus.en = 1'b0;  bus.clear = 1'b0;
      bus2.din = 4'd0; bus2.en = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      test_clean_lock();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      cnt      = 0;
      test_reset();
      rst = 1'b0;
      test_clean_lock();
      test_wrap();
      test_glitch();
      test_loss_relock();
      test_en_clear();
      test_saturation();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
